// File: rtl/req_pending_ctrl.sv
// Requester side of the fixed-priority grant path: edge-latched pending bits,
// one-hot grant capture and a valid/ready service handshake.
// Optional build macro PEND_OVF_EN enables the sticky per-line overflow flags.
module req_pending_ctrl #(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N-1:0]           evt,
    output logic [N-1:0]           req,
    input  logic [N-1:0]           gnt,
    output logic                   svc_valid,
    output logic [$clog2(N)-1:0]   svc_idx,
    input  logic                   svc_ready,
    output logic                   gnt_err,
    output logic [N-1:0]           ovf
);
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_evtQ;
    logic [N-1:0]    r_pend;
    logic            r_svcValid;
    logic [IW-1:0]   r_svcIdx;
    logic            r_gntErr;

    logic [N-1:0]    w_rise;
    logic [N-1:0]    w_clr;
    logic [N-1:0]    w_pendNext;
    logic            w_ack;
    logic            w_gntOneHot;
    logic            w_gntLegal;
    logic [IW-1:0]   w_gntIdx;

    assign w_rise      = evt & ~r_evtQ;
    assign w_ack       = r_svcValid & svc_ready;
    assign w_gntOneHot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
    assign w_gntLegal  = w_gntOneHot && ((gnt & ~r_pend) == '0);

    // A new rise beats a same-cycle handshake clear, so no event is dropped.
    assign w_pendNext  = (r_pend & ~w_clr) | w_rise;

    always_comb begin
        w_gntIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                w_gntIdx = IW'(i);
            end
        end
    end

    always_comb begin
        w_clr = '0;
        if (w_ack) begin
            w_clr[r_svcIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evtQ     <= '0;
            r_pend     <= '0;
            r_state    <= IDLE;
            r_svcValid <= 1'b0;
            r_svcIdx   <= '0;
            r_gntErr   <= 1'b0;
        end else begin
            r_evtQ <= evt;
            r_pend <= w_pendNext;
            case (r_state)
                IDLE: begin
                    if (gnt != '0) begin
                        if (w_gntLegal) begin
                            r_svcIdx   <= w_gntIdx;
                            r_svcValid <= 1'b1;
                            r_state    <= SERVE;
                        end else begin
                            r_gntErr <= 1'b1;
                        end
                    end
                end
                // Grant is ignored here; a later higher-priority event waits for IDLE.
                SERVE: begin
                    if (svc_ready) begin
                        r_svcValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_svcValid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

`ifdef PEND_OVF_EN
    logic [N-1:0] r_ovf;

    // Overflow means a rise merged into a bit that stays pending this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= r_ovf | (w_rise & r_pend & ~w_clr);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = '0;
`endif

    assign req       = r_pend;
    assign svc_valid = r_svcValid;
    assign svc_idx   = r_svcIdx;
    assign gnt_err   = r_gntErr;

endmodule

// File: tb/tb_req_pending_ctrl.sv
// Directed bench for req_pending_ctrl (N=4) with a fixed-priority grant model,
// bit 3 highest; the grant can be overridden to inject illegal patterns.
module tb_req_pending_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  evt;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        svc_valid;
    logic [1:0]  svc_idx;
    logic        svc_ready;
    logic        gnt_err;
    logic [3:0]  ovf;

    logic        gntForceEn;
    logic [3:0]  gntForce;

    int assertCount;
    int failCount;

`ifdef PEND_OVF_EN
    localparam logic [3:0] OVF_T5 = 4'b0100;
`else
    localparam logic [3:0] OVF_T5 = 4'b0000;
`endif

    req_pending_ctrl #(.N(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .evt       (evt),
        .req       (req),
        .gnt       (gnt),
        .svc_valid (svc_valid),
        .svc_idx   (svc_idx),
        .svc_ready (svc_ready),
        .gnt_err   (gnt_err),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority arbiter model, bypassed when the bench forces a grant.
    always_comb begin
        gnt = 4'b0000;
        if (gntForceEn)  gnt = gntForce;
        else if (req[3]) gnt = 4'b1000;
        else if (req[2]) gnt = 4'b0100;
        else if (req[1]) gnt = 4'b0010;
        else if (req[0]) gnt = 4'b0001;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] evtVal, input logic readyVal, input int cycles);
        evt       = evtVal;
        svc_ready = readyVal;
        step(cycles);
    endtask

    task automatic doReset();
        evt       = 4'b0000;
        svc_ready = 1'b0;
        reset_n   = 1'b0;
        #2;
        reset_n   = 1'b1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        gntForceEn  = 1'b0;
        gntForce    = 4'b0000;
        evt         = 4'b0000;
        svc_ready   = 1'b0;
        reset_n     = 1'b0;
        step(2);
        checkOutput("rst_req", 32'(req), 32'h0);
        checkOutput("rst_valid", 32'(svc_valid), 32'h0);
        checkOutput("rst_idx", 32'(svc_idx), 32'h0);
        checkOutput("rst_err", 32'(gnt_err), 32'h0);
        checkOutput("rst_ovf", 32'(ovf), 32'h0);
        reset_n = 1'b1;
        step(1);

        // Test 1: async reset while serving with pend=0110
        applyStimulus(4'b0110, 1'b0, 1);
        checkOutput("t1_req", 32'(req), 32'h6);
        step(1);
        checkOutput("t1_valid", 32'(svc_valid), 32'h1);
        checkOutput("t1_idx", 32'(svc_idx), 32'h2);
        evt     = 4'b0000;
        reset_n = 1'b0;
        #1;
        checkOutput("t1_async_req", 32'(req), 32'h0);
        checkOutput("t1_async_valid", 32'(svc_valid), 32'h0);
        checkOutput("t1_async_ovf", 32'(ovf), 32'h0);
        checkOutput("t1_async_err", 32'(gnt_err), 32'h0);
        #1;
        reset_n = 1'b1;
        step(3);
        checkOutput("t1_idle_req", 32'(req), 32'h0);
        checkOutput("t1_idle_valid", 32'(svc_valid), 32'h0);

        // Test 2: two events at once, served by priority
        applyStimulus(4'b0101, 1'b1, 1);
        checkOutput("t2_req", 32'(req), 32'h5);
        checkOutput("t2_valid_k", 32'(svc_valid), 32'h0);
        step(1);
        checkOutput("t2_valid1", 32'(svc_valid), 32'h1);
        checkOutput("t2_idx1", 32'(svc_idx), 32'h2);
        step(1);
        checkOutput("t2_valid_gap", 32'(svc_valid), 32'h0);
        checkOutput("t2_req_after1", 32'(req), 32'h1);
        step(1);
        checkOutput("t2_valid2", 32'(svc_valid), 32'h1);
        checkOutput("t2_idx2", 32'(svc_idx), 32'h0);
        step(1);
        checkOutput("t2_valid_end", 32'(svc_valid), 32'h0);
        checkOutput("t2_req_end", 32'(req), 32'h0);
        applyStimulus(4'b0000, 1'b0, 2);

        // Test 3: stalled service is not preempted
        applyStimulus(4'b0001, 1'b0, 2);
        checkOutput("t3_valid", 32'(svc_valid), 32'h1);
        checkOutput("t3_idx", 32'(svc_idx), 32'h0);
        evt = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checkOutput($sformatf("t3_hold_idx%0d", i), 32'(svc_idx), 32'h0);
            checkOutput($sformatf("t3_hold_valid%0d", i), 32'(svc_valid), 32'h1);
        end
        checkOutput("t3_req", 32'(req), 32'h9);
        applyStimulus(4'b1001, 1'b1, 1);
        checkOutput("t3_valid_gap", 32'(svc_valid), 32'h0);
        checkOutput("t3_req_after", 32'(req), 32'h8);
        step(1);
        checkOutput("t3_valid2", 32'(svc_valid), 32'h1);
        checkOutput("t3_idx2", 32'(svc_idx), 32'h3);
        step(1);
        checkOutput("t3_req_end", 32'(req), 32'h0);
        applyStimulus(4'b0000, 1'b0, 2);

        // Test 4: rise on the line being acknowledged keeps it pending
        applyStimulus(4'b0010, 1'b0, 2);
        checkOutput("t4_idx", 32'(svc_idx), 32'h1);
        applyStimulus(4'b0000, 1'b0, 1);
        applyStimulus(4'b0010, 1'b1, 1);
        checkOutput("t4_req_kept", 32'(req), 32'h2);
        checkOutput("t4_valid_gap", 32'(svc_valid), 32'h0);
        checkOutput("t4_ovf", 32'(ovf), 32'h0);
        step(1);
        checkOutput("t4_valid2", 32'(svc_valid), 32'h1);
        checkOutput("t4_idx2", 32'(svc_idx), 32'h1);
        step(1);
        checkOutput("t4_req_end", 32'(req), 32'h0);
        applyStimulus(4'b0000, 1'b0, 2);

        // Test 5: repeated event on a still-pending line
        applyStimulus(4'b0100, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1);
        checkOutput("t5_valid", 32'(svc_valid), 32'h1);
        applyStimulus(4'b0100, 1'b0, 1);
        checkOutput("t5_ovf", 32'(ovf), 32'(OVF_T5));
        applyStimulus(4'b0100, 1'b1, 1);
        checkOutput("t5_req_after", 32'(req), 32'h0);
        step(1);
        checkOutput("t5_no_second", 32'(svc_valid), 32'h0);
        applyStimulus(4'b0000, 1'b0, 2);
        checkOutput("t5_ovf_sticky", 32'(ovf), 32'(OVF_T5));

        // Test 6: illegal grants
        gntForceEn = 1'b1;
        gntForce   = 4'b0000;
        applyStimulus(4'b0011, 1'b0, 2);
        checkOutput("t6_req", 32'(req), 32'h3);
        checkOutput("t6_err_pre", 32'(gnt_err), 32'h0);
        checkOutput("t6_valid_pre", 32'(svc_valid), 32'h0);
        gntForce = 4'b1000;
        step(1);
        checkOutput("t6_err_notpend", 32'(gnt_err), 32'h1);
        checkOutput("t6_valid_notpend", 32'(svc_valid), 32'h0);
        gntForce = 4'b0000;
        doReset();
        step(1);
        checkOutput("t6_err_cleared", 32'(gnt_err), 32'h0);
        applyStimulus(4'b0011, 1'b0, 1);
        gntForce = 4'b0011;
        step(1);
        checkOutput("t6_err_multi", 32'(gnt_err), 32'h1);
        checkOutput("t6_valid_multi", 32'(svc_valid), 32'h0);
        gntForce = 4'b0000;
        step(2);
        checkOutput("t6_err_sticky", 32'(gnt_err), 32'h1);
        checkOutput("t6_valid_sticky", 32'(svc_valid), 32'h0);
        checkOutput("t6_idx_nocap", 32'(svc_idx), 32'h0);
        gntForceEn = 1'b0;
        step(1);
        checkOutput("t6_recover_valid", 32'(svc_valid), 32'h1);
        checkOutput("t6_recover_idx", 32'(svc_idx), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
